// File: rtl/regfile_write_arbiter.sv
// Single write-port arbiter: the pipeline writeback always wins, and secondary writes are queued.
// Queued writes track liveness, and a long wait raises a stall request.
// Optional same-cycle secondary bypass is enabled by defining REGFILE_WRITE_ARBITER_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_valid,
  input  logic [ADDR_WIDTH-1:0]        wb_addr,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         sec_valid,
  output logic                         sec_ready,
  input  logic [ADDR_WIDTH-1:0]        sec_addr,
  input  logic [DATA_WIDTH-1:0]        sec_data,
  output logic                         rf_we,
  output logic [ADDR_WIDTH-1:0]        rf_addr,
  output logic [DATA_WIDTH-1:0]        rf_data,
  output logic                         stall_req,
  output logic [(2**ADDR_WIDTH)-1:0]   pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int NREG   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0]     LIMIT_C   = WAIT_W'(STARVE_LIMIT);

  logic [ADDR_WIDTH-1:0] addr_q_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_q_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q_r, live_nxt_s;
  logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0]      count_r, count_nxt_s;
  logic [WAIT_W-1:0]     wait_r, wait_nxt_s;
  logic                  ready_r, stall_r, stall_nxt_s;
  logic                  wb_grant_s, empty_s, head_live_s, pop_s, accept_s, push_s, bypass_s;
  logic [NREG-1:0]       mask_s;

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
    onehot = {{(NREG-1){1'b0}}, 1'b1} << a;
  endfunction

  // Per-cycle grant, pop, accept and bypass decisions
  always_comb begin
    wb_grant_s  = rst && wb_valid && (wb_addr != ADDR_ZERO);
    empty_s     = (count_r == {CNT_W{1'b0}});
    head_live_s = live_q_r[rd_ptr_r] && !empty_s;
    pop_s       = rst && !wb_grant_s && !empty_s;
    accept_s    = sec_valid && ready_r;
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    bypass_s    = accept_s && empty_s && !wb_grant_s && (sec_addr != ADDR_ZERO);
`else
    bypass_s    = 1'b0;
`endif
    // Address-0 requests are accepted but never stored
    push_s      = accept_s && (sec_addr != ADDR_ZERO) && !bypass_s;
  end

  // Write-port mux: pipeline first, then live queue head, then bypass
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = ADDR_ZERO;
    rf_data = {DATA_WIDTH{1'b0}};
    if (wb_grant_s) begin
      rf_we   = 1'b1;
      rf_addr = wb_addr;
      rf_data = wb_data;
    end else if (pop_s && head_live_s) begin
      rf_we   = 1'b1;
      rf_addr = addr_q_r[rd_ptr_r];
      rf_data = data_q_r[rd_ptr_r];
    end else if (bypass_s) begin
      rf_we   = 1'b1;
      rf_addr = sec_addr;
      rf_data = sec_data;
    end else begin
      rf_we   = 1'b0;
    end
  end

  // Next liveness (a pipeline write kills older queued writes to the same register), occupancy, wait count
  always_comb begin
    live_nxt_s = live_q_r;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wb_grant_s && (addr_q_r[i] == wb_addr)) live_nxt_s[i] = 1'b0;
      else live_nxt_s[i] = live_q_r[i];
    end
    if (pop_s) live_nxt_s[rd_ptr_r] = 1'b0;
    else live_nxt_s[rd_ptr_r] = live_nxt_s[rd_ptr_r];
    if (push_s) live_nxt_s[wr_ptr_r] = 1'b1;
    else live_nxt_s[wr_ptr_r] = live_nxt_s[wr_ptr_r];

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 1'b1;
      2'b01:   count_nxt_s = count_r - 1'b1;
      default: count_nxt_s = count_r;
    endcase

    if (empty_s || pop_s) wait_nxt_s = {WAIT_W{1'b0}};
    else if (head_live_s && (wait_r < LIMIT_C)) wait_nxt_s = wait_r + 1'b1;
    else wait_nxt_s = wait_r;

    stall_nxt_s = !empty_s && !pop_s && (wait_r >= LIMIT_C);
  end

  // Pending mask from stored live entries only
  always_comb begin
    mask_s = {NREG{1'b0}};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live_q_r[i]) mask_s = mask_s | onehot(addr_q_r[i]);
      else mask_s = mask_s;
    end
  end

  // Queue storage, pointers, occupancy, starvation state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q_r[i] <= ADDR_ZERO;
        data_q_r[i] <= {DATA_WIDTH{1'b0}};
      end
      live_q_r <= {FIFO_DEPTH{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      wait_r   <= {WAIT_W{1'b0}};
      ready_r  <= 1'b0;
      stall_r  <= 1'b0;
    end else begin
      if (push_s) begin
        addr_q_r[wr_ptr_r] <= sec_addr;
        data_q_r[wr_ptr_r] <= sec_data;
        wr_ptr_r           <= wr_ptr_r + 1'b1;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      live_q_r <= live_nxt_s;
      count_r  <= count_nxt_s;
      wait_r   <= wait_nxt_s;
      ready_r  <= (count_nxt_s < DEPTH_C);
      stall_r  <= stall_nxt_s;
    end
  end

  assign sec_ready    = ready_r;
  assign stall_req    = stall_r;
  assign pending_mask = mask_s;
  assign fifo_count   = count_r;
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, secondary-request queue entries (power of two, >=2).
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, wait cycles before a stall is requested.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wb_valid  in  1  pipeline writeback request, never back-pressured.
REQ-008 SHALL have port wb_addr  in  ADDR_WIDTH  pipeline destination register.
REQ-009 SHALL have port wb_data  in  DATA_WIDTH  pipeline write data.
REQ-010 SHALL have port sec_valid  in  1  secondary requester (multi-cycle unit) request.
REQ-011 SHALL have port sec_ready  out  1  secondary request accepted when high with sec_valid.
REQ-012 SHALL have port sec_addr  in  ADDR_WIDTH  secondary destination register.
REQ-013 SHALL have port sec_data  in  DATA_WIDTH  secondary write data.
REQ-014 SHALL have ports rf_we out 1, rf_addr out ADDR_WIDTH, rf_data out DATA_WIDTH  single register-file write port.
REQ-015 SHALL have port stall_req  out  1  request to upstream to insert one writeback bubble.
REQ-016 SHALL have port pending_mask  out  2**ADDR_WIDTH  one bit per register with a live queued write.
REQ-017 SHALL have port fifo_count  out  $clog2(FIFO_DEPTH)+1  live-plus-dead queue occupancy.

Function
REQ-018 SHALL set sec_ready = (fifo_count < FIFO_DEPTH), registered-state only; no pop-through when full.
REQ-019 SHALL enqueue {addr,data,live=1} on sec_valid&&sec_ready; sec_addr==0 SHALL be accepted and discarded.
REQ-020 SHALL grant the write port, combinationally, to the pipeline when wb_valid&&wb_addr!=0: rf_we=1, rf_addr=wb_addr, rf_data=wb_data.
REQ-021 SHALL otherwise pop the queue head when non-empty; live head drives rf_we=1 with its addr/data, dead head pops with rf_we=0.
REQ-022 SHALL drive rf_we=0, rf_addr=0, rf_data=0 when no grant.
REQ-023 SHALL on each pipeline write to address A clear live on every queued entry with addr A in the same edge (younger pipeline write wins).
REQ-024 SHALL handle simultaneous push and pop with fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL derive pending_mask as OR of one-hot(addr) over live entries, from registered state.
REQ-026 SHALL count wait cycles while head is live and not granted; counter clears on head pop or empty queue.
REQ-027 SHALL assert stall_req, registered, from the cycle after count reaches STARVE_LIMIT until the head is popped; pipeline still wins if wb_valid arrives during stall_req.
REQ-028 SHALL never drop or reorder live secondary writes.

Reset
REQ-029 SHALL while rst low: queue empty, pointers 0, wait counter 0, stall_req 0, pending_mask 0, fifo_count 0, sec_ready 0, rf_we 0.
REQ-030 SHALL discard queued entries on mid-operation reset; sec_ready rises first cycle after rst deasserts.

Configuration
REQ-031 SHALL with REGFILE_WRITE_ARBITER_BYPASS_EN defined write a secondary request directly (same cycle, not enqueued) when queue empty and no pipeline grant.
REQ-032 SHALL without REGFILE_WRITE_ARBITER_BYPASS_EN always enqueue; earliest rf_we for a secondary request is the cycle after acceptance.

Verification
REQ-033 SHALL cover: idle, sec write x5=0xAA -> rf_we next cycle (macro off) / same cycle (macro on), addr 5, data 0xAA.
REQ-034 SHALL cover: wb_valid every cycle, 4 sec requests -> sec_ready low at count 4, stall_req high after 8 waits, head written in first wb_valid=0 cycle.
REQ-035 SHALL cover: queue x7=0x11, then wb x7=0x22 -> pending_mask[7] clears, dead entry pops rf_we=0, final x7=0x22.
REQ-036 SHALL cover: sec_addr=0 and wb_addr=0 -> no rf_we, fifo_count unchanged, pending_mask[0]=0.
REQ-037 SHALL cover: queue full, rst pulsed low mid-stream -> all outputs zero during reset, count 0, sec_ready 1 after release.
